ervp_uncached_axi_bridge: RTL



---
 rtl/ervp_uncached_axi_bridge_if.sv | 73 +++++++
 rtl/ervp_uncached_axi_bridge.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ervp_uncached_axi_bridge_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces for ervp_uncached_axi_bridge.
//
// ervp_uca_if   : single-beat uncacheable request/reply stream from the cache
//                 access splitter.
//                 modport master = splitter side (issues requests)
//                 modport slave  = bridge side (accepts requests, returns reads)
//   rcqvalid/rcqready          request handshake
//   rcqaddr/rcqwrite           request address and direction
//   rcqwstrb/rcqwdata          write strobes and data
//   rcyvalid/rcyrdata          read reply, one-cycle pulse, no back-pressure
//
// ervp_axil_if  : AXI4-Lite bus without prot signals.
//                 modport master = bridge side
//                 modport slave  = memory / peripheral side
//   aw*, w*, b*, ar*, r*       standard AXI4-Lite channels, resp is 2 bits
// ----------------------------------------------------------------------------
interface ervp_uca_if #(
   parameter int BW_ADDR   = 32,
   parameter int BW_ACCESS = 32
);
   logic                   rcqvalid;
   logic                   rcqready;
   logic [BW_ADDR-1:0]     rcqaddr;
   logic                   rcqwrite;
   logic [BW_ACCESS/8-1:0] rcqwstrb;
   logic [BW_ACCESS-1:0]   rcqwdata;
   logic                   rcyvalid;
   logic [BW_ACCESS-1:0]   rcyrdata;

   modport master (
      output rcqvalid, rcqaddr, rcqwrite, rcqwstrb, rcqwdata,
      input  rcqready, rcyvalid, rcyrdata
   );

   modport slave (
      input  rcqvalid, rcqaddr, rcqwrite, rcqwstrb, rcqwdata,
      output rcqready, rcyvalid, rcyrdata
   );
endinterface

interface ervp_axil_if #(
   parameter int BW_ADDR   = 32,
   parameter int BW_ACCESS = 32
);
   logic                   awvalid;
   logic                   awready;
   logic [BW_ADDR-1:0]     awaddr;
   logic                   wvalid;
   logic                   wready;
   logic [BW_ACCESS-1:0]   wdata;
   logic [BW_ACCESS/8-1:0] wstrb;
   logic                   bvalid;
   logic                   bready;
   logic [1:0]             bresp;
   logic                   arvalid;
   logic                   arready;
   logic [BW_ADDR-1:0]     araddr;
   logic                   rvalid;
   logic                   rready;
   logic [BW_ACCESS-1:0]   rdata;
   logic [1:0]             rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/ervp_uncached_axi_bridge.sv
// ----------------------------------------------------------------------------
// ervp_uncached_axi_bridge
//
// Turns the single-beat uncacheable request stream of the cache access
// splitter into AXI4-Lite master transactions. One read is in flight at a
// time, replies come back in request order, and writes may optionally be
// posted.
//
// Optional feature macro: ERVP_UCA_WRITE_POSTING_EN
//   defined   : a write returns to IDLE as soon as AW and W are both done;
//               up to MAX_POSTED_WRITE B responses may be outstanding, and a
//               read waits until all of them have drained.
//   undefined : every write waits for its B response before the next request.
//
// Ports:
//   clk      clock
//   rstnn    asynchronous active-low reset
//   clear    synchronous clear of the sticky error flag
//   enable   when low, no new request is accepted
//   busy     FSM not idle or write responses still outstanding
//   error    sticky, set by any nonzero bresp/rresp
//   uca      request/reply stream (slave modport)
//   axi      AXI4-Lite master bus
// ----------------------------------------------------------------------------
module ervp_uncached_axi_bridge #(
   parameter int BW_ADDR          = 32,
   parameter int BW_ACCESS        = 32,
   parameter int MAX_POSTED_WRITE = 4
) (
   input  logic        clk,
   input  logic        rstnn,
   input  logic        clear,
   input  logic        enable,
   output logic        busy,
   output logic        error,
   ervp_uca_if.slave   uca,
   ervp_axil_if.master axi
);

   localparam int BW_STRB  = BW_ACCESS / 8;
   localparam int BW_COUNT = $clog2(MAX_POSTED_WRITE) + 1;
`ifdef ERVP_UCA_WRITE_POSTING_EN
   localparam logic [BW_COUNT-1:0] COUNT_LIMIT = BW_COUNT'(MAX_POSTED_WRITE);
`endif

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WAIT_B,
      RD_AR,
      WAIT_R
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [BW_ADDR-1:0]   addr_reg;
   logic [BW_ACCESS-1:0] wdata_reg;
   logic [BW_STRB-1:0]   wstrb_reg;
   logic                 aw_done;
   logic                 w_done;
   logic [BW_COUNT-1:0]  write_count;
   logic                 rcy_valid_reg;
   logic [BW_ACCESS-1:0] rdata_reg;
   logic                 error_reg;

   logic                 accept;
   logic                 aw_hs;
   logic                 w_hs;
   logic                 ar_hs;
   logic                 r_hs;
   logic                 b_hs;
   logic                 write_complete;
   logic                 write_credit_ok;
   logic                 no_pending_write;
   logic                 resp_error;

   // Channel handshakes and the point where a write has finished both its
   // address and data phases (the two may complete in either order).
   assign aw_hs          = axi.awvalid & axi.awready;
   assign w_hs           = axi.wvalid & axi.wready;
   assign ar_hs          = axi.arvalid & axi.arready;
   assign r_hs           = axi.rvalid & axi.rready;
   assign b_hs           = axi.bvalid & axi.bready;
   assign write_complete = (state == WR) & (aw_done | aw_hs) & (w_done | w_hs);
   assign resp_error     = (b_hs & (axi.bresp != 2'b00)) | (r_hs & (axi.rresp != 2'b00));

   // A write may go whenever there is room for another outstanding B response;
   // a read must wait until every posted write has been acknowledged, which
   // keeps read-after-write ordering without any address comparison.
   assign no_pending_write = (write_count == '0);
`ifdef ERVP_UCA_WRITE_POSTING_EN
   assign write_credit_ok = (write_count < COUNT_LIMIT);
`else
   assign write_credit_ok = 1'b1;
`endif

   // Ready is gated by the reset so that nothing is accepted while the block
   // is held in reset even though the FSM already sits in IDLE.
   assign uca.rcqready = rstnn & (state == IDLE) & enable &
                         (uca.rcqwrite ? write_credit_ok : no_pending_write);
   assign accept       = uca.rcqvalid & uca.rcqready;

   // Bus outputs are decoded only from registers, so no request input ever
   // reaches an AXI output combinationally.
   assign axi.awvalid  = (state == WR) & ~aw_done;
   assign axi.awaddr   = addr_reg;
   assign axi.wvalid   = (state == WR) & ~w_done;
   assign axi.wdata    = wdata_reg;
   assign axi.wstrb    = wstrb_reg;
   assign axi.bready   = ~no_pending_write;
   assign axi.arvalid  = (state == RD_AR);
   assign axi.araddr   = addr_reg;
   assign axi.rready   = (state == WAIT_R);

   assign uca.rcyvalid = rcy_valid_reg;
   assign uca.rcyrdata = rdata_reg;
   assign error        = error_reg;
   assign busy         = (state != IDLE) | ~no_pending_write;

   // State register.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. With posting, WR goes straight back to IDLE and the B
   // response is collected in the background by the outstanding counter;
   // without posting, WR parks in WAIT_B until that response arrives.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = uca.rcqwrite ? WR : RD_AR;
            end
         end
         WR: begin
            if (write_complete) begin
`ifdef ERVP_UCA_WRITE_POSTING_EN
               state_next = IDLE;
`else
               state_next = WAIT_B;
`endif
            end
         end
         WAIT_B: begin
            if (b_hs) begin
               state_next = IDLE;
            end
         end
         RD_AR: begin
            if (ar_hs) begin
               state_next = WAIT_R;
            end
         end
         WAIT_R: begin
            if (r_hs) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture the request on acceptance; address, data and strobes are held
   // stable for the whole AXI transaction.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         addr_reg  <= '0;
         wdata_reg <= '0;
         wstrb_reg <= '0;
      end else if (accept) begin
         addr_reg  <= uca.rcqaddr;
         wdata_reg <= uca.rcqwdata;
         wstrb_reg <= uca.rcqwstrb;
      end
   end

   // AW and W are independent channels; each drops its valid after its own
   // handshake and the flags remember which side has already finished.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (accept) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_done <= 1'b1;
         end
         if (w_hs) begin
            w_done <= 1'b1;
         end
      end
   end

   // Outstanding write responses: counts up when a write finishes its AW and
   // W phases and down on every B handshake; both together cancel out.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         write_count <= '0;
      end else begin
         case ({write_complete, b_hs})
            2'b10:   write_count <= write_count + BW_COUNT'(1);
            2'b01:   write_count <= write_count - BW_COUNT'(1);
            default: write_count <= write_count;
         endcase
      end
   end

   // Read reply: the data is registered on the R handshake and the reply
   // pulse follows one cycle later, together with the return to IDLE.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         rcy_valid_reg <= 1'b0;
         rdata_reg     <= '0;
      end else begin
         rcy_valid_reg <= r_hs;
         if (r_hs) begin
            rdata_reg <= axi.rdata;
         end
      end
   end

   // Sticky error flag; a new error in the same cycle as a clear wins so that
   // no error report can be lost.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         error_reg <= 1'b0;
      end else begin
         error_reg <= resp_error | (error_reg & ~clear);
      end
   end

endmodule
